imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian bytes into 32-bit words and writes them to imem.
// Latency: imem_we asserts the cycle after the 4th byte handshake of a word; 1 word per 5 cycles at best.
// Backpressure: byte_ready is a registered state decode (RECV/CHECK only); byte_valid=0 stalls forever.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   start, len_words    - load request and word count, honoured in IDLE/DONE/ERR only
//   byte_valid/_data    - upstream byte stream; byte_ready - byte accepted this cycle
//   imem_we/addr/wd     - instruction-memory write port (byte address, word aligned)
//   core_rst            - holds the core in reset everywhere except DONE
//   busy, done, error   - status flags
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte
// that makes the 8-bit sum of all data bytes plus itself equal zero.

module imem_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wd,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] len_q;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_buf;
    logic             we_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    wire hs = byte_valid && byte_ready;

    // A reset arriving during the WRITE cycle must keep the strobe low in that
    // same cycle, so the registered strobe is gated by rst on the way out.
    assign imem_we = we_q && !rst;

    // Status flags packed as {byte_ready, core_rst, busy, done, error}.
    function automatic logic [4:0] flags_of(input state_t s);
        case (s)
            IDLE:    flags_of = 5'b01000;
            RECV:    flags_of = 5'b11100;
            WRITE:   flags_of = 5'b01100;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:   flags_of = 5'b11100;
`endif
            DONE:    flags_of = 5'b00010;
            ERR:     flags_of = 5'b01001;
            default: flags_of = 5'b01000;
        endcase
    endfunction

    // Moves to a state and loads the flag registers for that state together,
    // keeping all status outputs registered and consistent with the state.
    task automatic go(input state_t s);
        state <= s;
        {byte_ready, core_rst, busy, done, error} <= flags_of(s);
    endtask

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            len_q      <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wd    <= '0;
            byte_ready <= 1'b0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        if (len_words > DEPTH_C) begin
                            go(ERR);
                        end else if (len_words == '0) begin
                            go(DONE);
                        end else begin
                            len_q    <= len_words;
                            word_cnt <= '0;
                            byte_cnt <= '0;
                            word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                            go(RECV);
                        end
                    end
                end

                RECV: begin
                    if (hs) begin
                        word_buf[8*byte_cnt +: 8] <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= 8'(csum + byte_data);
`endif
                        if (byte_cnt == 2'd3) begin
                            // The 4th byte is taken straight from the input so the
                            // write can go out in the very next cycle.
                            byte_cnt  <= '0;
                            we_q      <= 1'b1;
                            imem_addr <= 32'({word_cnt, 2'b00});
                            imem_wd   <= {byte_data, word_buf[23:0]};
                            go(WRITE);
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    if (word_cnt == len_q - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        go(CHECK);
`else
                        go(DONE);
`endif
                    end else begin
                        go(RECV);
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (hs) begin
                        if (8'(csum + byte_data) == 8'd0) begin
                            go(DONE);
                        end else begin
                            go(ERR);
                        end
                    end
                end
`endif

                default: go(IDLE);
            endcase
        end
    end

endmodule
